vga_timing_pipe: RTL and testbench

VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_delay_line.sv | 29 ++
 rtl/vga_timing_pipe.sv | 150 +++++++++++++++
 tb/tb_vga_timing_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480 defaults, the per-pixel timing bundle
// carried down the latency pipeline, and the line/frame total helper.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic display_on;
    logic line_start;
    logic frame_start;
  } vga_timing_t;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register; clear forces every stage back to zero.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0][WIDTH-1:0] stages;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      stages <= '0;
    end else if (clear) begin
      stages <= '0;
    end else if (tick) begin
      stages[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign data_out = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with a pixel-source latency pipeline: the sync, blanking
// and strobes are delayed so they line up with colour returned by the source.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FRONT       = VGA_H_FRONT,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BACK        = VGA_H_BACK,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FRONT       = VGA_V_FRONT,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BACK        = VGA_V_BACK,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0,
  parameter int CLOCK_DIV     = 2,
  parameter int PIXEL_LATENCY = 2,
  parameter int COLOR_BITS    = 4,
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   enable_in,
  input  logic [COLOR_BITS-1:0]  pixel_red_in,
  input  logic [COLOR_BITS-1:0]  pixel_green_in,
  input  logic [COLOR_BITS-1:0]  pixel_blue_in,
  output logic [WIDTH_BITS-1:0]  pixel_x_out,
  output logic [HEIGHT_BITS-1:0] pixel_y_out,
  output logic                   pixel_request_out,
  output logic                   pixel_tick_out,
  output logic                   line_start_out,
  output logic                   frame_start_out,
  output logic [7:0]             frame_count_out,
  output logic [COLOR_BITS-1:0]  vga_red_out,
  output logic [COLOR_BITS-1:0]  vga_green_out,
  output logic [COLOR_BITS-1:0]  vga_blue_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   display_on_out
);

  localparam int   H_TOTAL  = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int   V_TOTAL  = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int   HS_START = H_ACTIVE + H_FRONT;
  localparam int   VS_START = V_ACTIVE + V_FRONT;
  localparam logic H_IDLE   = (H_SYNC_POL == 0);
  localparam logic V_IDLE   = (V_SYNC_POL == 0);

  logic                   run, tick, tick_d, in_frame;
  logic [3:0]             div_cnt;
  logic [WIDTH_BITS-1:0]  h_cnt;
  logic [HEIGHT_BITS-1:0] v_cnt;
  logic [COLOR_BITS-1:0]  red_q, green_q, blue_q;
  vga_timing_t            raw, dly;

  // Outputs are gated combinationally so disable and reset take effect at once.
  assign run  = enable_in & reset_n_in;
  assign tick = run && (div_cnt == 4'(CLOCK_DIV - 1));

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      tick_d  <= 1'b0;
    end else begin
      tick_d <= tick;
      if (!enable_in || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 4'd1;
      if (!enable_in) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (tick) begin
        if (h_cnt == WIDTH_BITS'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == HEIGHT_BITS'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    raw.display_on  = (h_cnt < WIDTH_BITS'(H_ACTIVE)) && (v_cnt < HEIGHT_BITS'(V_ACTIVE));
    raw.h_sync      = (h_cnt >= WIDTH_BITS'(HS_START)) && (h_cnt < WIDTH_BITS'(HS_START + H_SYNC));
    raw.v_sync      = (v_cnt >= HEIGHT_BITS'(VS_START)) && (v_cnt < HEIGHT_BITS'(VS_START + V_SYNC));
    raw.line_start  = (h_cnt == '0);
    raw.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  vga_delay_line #(
    .DEPTH (PIXEL_LATENCY),
    .WIDTH ($bits(vga_timing_t))
  ) u_delay (
    .gclk     (clock_in),
    .grst_n   (reset_n_in),
    .tick     (tick),
    .clear    (!enable_in),
    .data_in  (raw),
    .data_out (dly)
  );

  // Colour captured on the tick ending the period before its coordinate is shown;
  // blanking is applied with the delayed display-on of that same coordinate.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (!enable_in) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (tick) begin
      red_q   <= pixel_red_in;
      green_q <= pixel_green_in;
      blue_q  <= pixel_blue_in;
    end
  end

  // Count completed frames: a frame start only closes a frame already in progress,
  // so the first start after enable (or an aborted frame) is not counted.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      frame_count_out <= '0;
      in_frame        <= 1'b0;
    end else if (!enable_in) begin
      in_frame <= 1'b0;
    end else if (frame_start_out) begin
      if (in_frame) frame_count_out <= frame_count_out + 8'd1;
      in_frame <= 1'b1;
    end
  end

  assign pixel_x_out       = h_cnt;
  assign pixel_y_out       = v_cnt;
  assign pixel_tick_out    = tick;
  assign pixel_request_out = run & raw.display_on;
  assign display_on_out    = run & dly.display_on;
  assign line_start_out    = run & tick_d & dly.line_start;
  assign frame_start_out   = run & tick_d & dly.frame_start;
  assign h_sync_out        = run ? (dly.h_sync ^ H_IDLE) : H_IDLE;
  assign v_sync_out        = run ? (dly.v_sync ^ V_IDLE) : V_IDLE;
  assign vga_red_out       = display_on_out ? red_q   : '0;
  assign vga_green_out     = display_on_out ? green_q : '0;
  assign vga_blue_out      = display_on_out ? blue_q  : '0;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: small 14x7 timing at DIV=1 (table + frame sweep + enable drop)
// and a DIV=3 positive-polarity instance (tick cadence, strobes, async reset).
module tb_vga_timing_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- DUT 1: DIV=1, LAT=2, active-low syncs ----------------
  logic       rst1, en1;
  logic [3:0] red1, grn1, blu1;
  logic [9:0] x1, y1;
  logic       req1, tick1, ls1, fs1, hs1, vs1, de1;
  logic [7:0] fc1;
  logic [3:0] vr1, vg1, vb1;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CLOCK_DIV(1), .PIXEL_LATENCY(2),
    .COLOR_BITS(4), .WIDTH_BITS(10), .HEIGHT_BITS(10)
  ) dut (
    .clock_in(clk), .reset_n_in(rst1), .enable_in(en1),
    .pixel_red_in(red1), .pixel_green_in(grn1), .pixel_blue_in(blu1),
    .pixel_x_out(x1), .pixel_y_out(y1), .pixel_request_out(req1),
    .pixel_tick_out(tick1), .line_start_out(ls1), .frame_start_out(fs1),
    .frame_count_out(fc1), .vga_red_out(vr1), .vga_green_out(vg1),
    .vga_blue_out(vb1), .h_sync_out(hs1), .v_sync_out(vs1), .display_on_out(de1)
  );

  // Pixel source: returns the requested x as red one pixel period later.
  always @(posedge clk) if (tick1) red1 <= x1[3:0];
  assign grn1 = 4'h5;
  assign blu1 = 4'hA;

  // ---------------- DUT 3: DIV=3, LAT=2, active-high syncs ----------------
  logic       rst3, en3;
  logic [3:0] red3, grn3, blu3;
  logic [9:0] x3, y3;
  logic       req3, tick3, ls3, fs3, hs3, vs3, de3;
  logic [7:0] fc3;
  logic [3:0] vr3, vg3, vb3;

  assign red3 = 4'hC;
  assign grn3 = 4'h3;
  assign blu3 = 4'h9;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CLOCK_DIV(3), .PIXEL_LATENCY(2),
    .COLOR_BITS(4), .WIDTH_BITS(10), .HEIGHT_BITS(10)
  ) dut3 (
    .clock_in(clk), .reset_n_in(rst3), .enable_in(en3),
    .pixel_red_in(red3), .pixel_green_in(grn3), .pixel_blue_in(blu3),
    .pixel_x_out(x3), .pixel_y_out(y3), .pixel_request_out(req3),
    .pixel_tick_out(tick3), .line_start_out(ls3), .frame_start_out(fs3),
    .frame_count_out(fc3), .vga_red_out(vr3), .vga_green_out(vg3),
    .vga_blue_out(vb3), .h_sync_out(hs3), .v_sync_out(vs3), .display_on_out(de3)
  );

  // Vector: clock edges since enable, counters, aligned outputs of coordinate k-2.
  typedef struct {
    int   cyc;
    int   x, y;
    logic hs, vs, de, ls, fs;
    int   fc;
    int   red;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int k, e, hm, vm, m, vis, hs_lo, vs_lo;
    logic exp_de, found;

    vecs[0]  = '{0,   0,  0, 1, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1,   1,  0, 1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{2,   2,  0, 1, 1, 1, 1, 1, 0, 0};
    vecs[3]  = '{3,   3,  0, 1, 1, 1, 0, 0, 0, 1};
    vecs[4]  = '{11,  11, 0, 1, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{12,  12, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{13,  13, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{14,  0,  1, 1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{16,  2,  1, 1, 1, 1, 1, 0, 0, 0};
    vecs[9]  = '{72,  2,  5, 1, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{84,  0,  6, 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{86,  2,  6, 1, 1, 0, 1, 0, 0, 0};
    vecs[12] = '{98,  0,  0, 1, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{100, 2,  0, 1, 1, 1, 1, 1, 0, 0};
    vecs[14] = '{101, 3,  0, 1, 1, 1, 0, 0, 1, 1};

    rst1 = 1'b0; en1 = 1'b0; rst3 = 1'b0; en3 = 1'b0; red1 = '0;
    #3;
    // Reset state
    chk("rst_hs1", hs1, 1);  chk("rst_vs1", vs1, 1);
    chk("rst_de1", de1, 0);  chk("rst_fc1", fc1, 0);
    chk("rst_red1", vr1, 0); chk("rst_fs1", fs1, 0);
    chk("rst_hs3_pol1", hs3, 0); chk("rst_vs3_pol1", vs3, 0);

    @(negedge clk); rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hs3", hs3, 0); chk("idle_tick3", tick3, 0); chk("idle_x1", x1, 0);

    // ---- table-driven free run of DUT 1 ----
    en1 = 1'b1; #1;
    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].cyc > k) begin
        repeat (vecs[i].cyc - k) @(posedge clk);
        @(negedge clk);
        k = vecs[i].cyc;
      end
      chk($sformatf("v%0d_x", k),   x1,  vecs[i].x);
      chk($sformatf("v%0d_y", k),   y1,  vecs[i].y);
      chk($sformatf("v%0d_hs", k),  hs1, vecs[i].hs);
      chk($sformatf("v%0d_vs", k),  vs1, vecs[i].vs);
      chk($sformatf("v%0d_de", k),  de1, vecs[i].de);
      chk($sformatf("v%0d_ls", k),  ls1, vecs[i].ls);
      chk($sformatf("v%0d_fs", k),  fs1, vecs[i].fs);
      chk($sformatf("v%0d_fc", k),  fc1, vecs[i].fc);
      chk($sformatf("v%0d_red", k), vr1, vecs[i].red);
    end

    // ---- one full frame sweep: colour alignment, request, counts ----
    vis = 0; hs_lo = 0; vs_lo = 0;
    repeat (98) begin
      @(posedge clk); @(negedge clk); k++;
      m = k - 2; hm = m % 14; vm = (m / 14) % 7;
      exp_de = (hm < 8) && (vm < 4);
      chk("sweep_de", de1, exp_de);
      chk("sweep_red", vr1, exp_de ? hm : 0);
      chk("sweep_grn", vg1, exp_de ? 5 : 0);
      chk("sweep_req", req1, ((k % 14) < 8) && (((k / 14) % 7) < 4));
      if (de1) vis++;
      if (!hs1) hs_lo++;
      if (!vs1) vs_lo++;
    end
    chk("visible_per_frame", vis, 32);
    chk("hsync_low_per_frame", hs_lo, 14);
    chk("vsync_low_per_frame", vs_lo, 14);

    // ---- enable dropped at (5,2), then restored ----
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (x1 == 5 && y1 == 2) found = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
    chk("find_5_2", found, 1);
    chk("fc_before_drop", fc1, 2);
    en1 = 1'b0; #1;
    chk("drop_de", de1, 0); chk("drop_red", vr1, 0); chk("drop_hs", hs1, 1);
    chk("drop_vs", vs1, 1); chk("drop_tick", tick1, 0); chk("drop_req", req1, 0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("idle_x", x1, 0); chk("idle_y", y1, 0); chk("idle_fc", fc1, 2);
    en1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("restart1_fs", fs1, 0);
    @(posedge clk); @(negedge clk);
    chk("restart2_fs", fs1, 1); chk("restart2_ls", ls1, 1); chk("restart2_fc", fc1, 2);
    @(posedge clk); @(negedge clk);
    chk("restart3_fs", fs1, 0); chk("restart3_fc", fc1, 2);

    // ---- DUT 3: DIV=3 cadence, single-clock strobes, active-high sync ----
    en3 = 1'b1; #1;
    chk("d3_tick0", tick3, 0); chk("d3_x0", x3, 0);
    for (e = 1; e <= 42; e++) begin
      @(posedge clk); @(negedge clk);
      if (e <= 9) begin
        chk($sformatf("d3_tick_e%0d", e), tick3, (e % 3) == 2);
        chk($sformatf("d3_x_e%0d", e), x3, e / 3);
        chk($sformatf("d3_ls_e%0d", e), ls3, e == 6);
        chk($sformatf("d3_fs_e%0d", e), fs3, e == 6);
      end
      if (e == 35) chk("d3_hs_e35", hs3, 0);
      if (e == 36) chk("d3_hs_e36", hs3, 1);
      if (e == 41) chk("d3_hs_e41", hs3, 1);
      if (e == 42) chk("d3_hs_e42", hs3, 0);
    end
    chk("d3_vs_idle", vs3, 0);
    repeat (310 - 42) @(posedge clk);
    @(negedge clk);
    chk("d3_fc_e310", fc3, 1); chk("d3_red_e310", vr3, 12); chk("d3_de_e310", de3, 1);

    // ---- asynchronous reset mid-line ----
    #2 rst3 = 1'b0;
    #1;
    chk("ar_x", x3, 0); chk("ar_y", y3, 0); chk("ar_fc", fc3, 0);
    chk("ar_red", vr3, 0); chk("ar_de", de3, 0); chk("ar_hs", hs3, 0);
    chk("ar_vs", vs3, 0); chk("ar_tick", tick3, 0); chk("ar_ls", ls3, 0);
    @(negedge clk); rst3 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_tick1", tick3, 0);
    @(posedge clk); @(negedge clk);
    chk("rel_tick2", tick3, 1); chk("rel_x2", x3, 0);
    @(posedge clk); @(negedge clk);
    chk("rel_x3", x3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
